// File: rtl/divide_unit.sv
// Multicycle restoring divider for MIPS div/divu: one quotient bit per cycle,
// sign fix-up afterwards, Hi = remainder and Lo = quotient, one-cycle EndDivFlag.
module divide_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             EndDivFlag,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic [2:0]       dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Handshake: Start is taken only in S_IDLE; EndDivFlag is high for exactly
   // the one cycle spent in S_DONE, and Start in any other state is dropped.
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, b_abs, rem, quot;
   logic             sgn_q, neg_q, neg_r;
   logic [CW-1:0]    cnt;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs_c, b_abs_c;
   logic [WIDTH:0]   shifted, trial;

   assign a_neg   = sgn_q & a_q[WIDTH-1];
   assign b_neg   = sgn_q & b_q[WIDTH-1];
   assign a_abs_c = a_neg ? (~a_q + 1'b1) : a_q;
   assign b_abs_c = b_neg ? (~b_q + 1'b1) : b_q;

   // One extra bit keeps the shifted remainder and the trial sign exact.
   assign shifted = {rem, quot[WIDTH-1]};
   assign trial   = shifted - {1'b0, b_abs};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      Busy       = 1'b0;
      EndDivFlag = 1'b0;
      case (state)
         S_IDLE: if (Start) state_nx = S_PREP;
         S_PREP: begin
            Busy = 1'b1;
            // A zero divisor still passes through S_FIX so the trap path ends
            // one cycle after the sample edge; S_FIX leaves Hi/Lo alone then.
            state_nx = (b_q == '0) ? S_FIX : S_ITER;
         end
         S_ITER: begin
            Busy = 1'b1;
            if (cnt == '0) state_nx = S_FIX;
         end
         S_FIX: begin
            Busy     = 1'b1;
            state_nx = S_DONE;
         end
         S_DONE: begin
            EndDivFlag = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         b_abs   <= '0;
         rem     <= '0;
         quot    <= '0;
         cnt     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         DivZero <= 1'b0;
         Hi      <= '0;
         Lo      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  a_q     <= A;
                  b_q     <= B;
                  sgn_q   <= Signed;
                  DivZero <= 1'b0;
               end
            end
            S_PREP: begin
               if (b_q == '0) begin
                  DivZero <= 1'b1;
               end else begin
                  b_abs <= b_abs_c;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  rem   <= '0;
                  quot  <= a_abs_c;
                  cnt   <= CW'(WIDTH - 1);
               end
            end
            S_ITER: begin
               if (trial[WIDTH]) begin
                  rem  <= shifted[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], 1'b0};
               end else begin
                  rem  <= trial[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], 1'b1};
               end
               cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               if (!DivZero) begin
                  Lo <= neg_q ? (~quot + 1'b1) : quot;
                  Hi <= neg_r ? (~rem + 1'b1) : rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_divide_unit.sv
// Randomized bench for divide_unit: operands are checked against a 64-bit
// arithmetic reference, plus handshake timing, divide-by-zero and reset cases.
module tb_divide_unit;

   localparam int W         = 32;
   localparam int IDLE_CODE = 0;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         Start = 1'b0;
   logic         Signed = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Busy, EndDivFlag, DivZero;
   logic [W-1:0] Hi, Lo;
   logic [2:0]   dbg_state;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mdl_hi = '0;
   logic [W-1:0] mdl_lo = '0;
   logic         mdl_dz = 1'b0;

   divide_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed),
      .A(A), .B(B), .Busy(Busy), .EndDivFlag(EndDivFlag), .DivZero(DivZero),
      .Hi(Hi), .Lo(Lo), .dbg_state(dbg_state)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // MIPS semantics from plain 64-bit arithmetic: truncating quotient,
   // remainder with the dividend's sign; results wrap to W bits.
   task automatic push_expect(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      if (b == '0) begin
         mdl_dz = 1'b1;
      end else begin
         sa = sg ? {{32{a[W-1]}}, a} : {32'b0, a};
         sb = sg ? {{32{b[W-1]}}, b} : {32'b0, b};
         q  = sa / sb;
         r  = sa % sb;
         mdl_lo = q[W-1:0];
         mdl_hi = r[W-1:0];
         mdl_dz = 1'b0;
      end
      exp_q.push_back(mdl_lo);
      exp_q.push_back(mdl_hi);
   endtask

   task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
      int           cyc;
      int           busy_bad;
      int           exp_lat;
      logic [W-1:0] e_lo, e_hi;
      exp_lat = (b == '0) ? 2 : W + 2;
      push_expect(sg, a, b);
      @(negedge Clk);
      Start = 1'b1; A = a; B = b; Signed = sg;
      @(posedge Clk); #1;
      Start = 1'b0; A = $urandom; B = $urandom; Signed = 1'($urandom);
      check("busy_e0", Busy, 1);
      check("dz_clear", DivZero, 0);
      cyc = 0;
      busy_bad = 0;
      while (!EndDivFlag && cyc < 100) begin
         @(posedge Clk); #1;
         cyc++;
         if (!EndDivFlag && !Busy) busy_bad++;
         if (cyc == 1 && b == '0) check("dz_early", DivZero, 1);
         if (poke && cyc == 4) begin
            Start = 1'b1; A = $urandom; B = $urandom_range(1, 9); Signed = ~sg;
         end
         if (poke && cyc == 5) Start = 1'b0;
      end
      check("latency", cyc, exp_lat);
      check("busy_hold", busy_bad, 0);
      check("busy_done", Busy, 0);
      e_lo = exp_q.pop_front();
      e_hi = exp_q.pop_front();
      check("lo", Lo, e_lo);
      check("hi", Hi, e_hi);
      check("divzero", DivZero, mdl_dz);
      if (poke) begin
         Start = 1'b1; A = $urandom; B = $urandom_range(1, 9); Signed = ~sg;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      check("pulse_end", EndDivFlag, 0);
      check("idle_state", dbg_state, IDLE_CODE);
      check("busy_idle", Busy, 0);
   endtask

   task automatic reset_mid_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge Clk);
      Start = 1'b1; A = a; B = b; Signed = 1'b0;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (9) @(posedge Clk);
      #3 Reset = 1'b1;
      #1;
      check("rst_busy", Busy, 0);
      check("rst_end", EndDivFlag, 0);
      check("rst_dz", DivZero, 0);
      check("rst_hi", Hi, 0);
      check("rst_lo", Lo, 0);
      check("rst_state", dbg_state, IDLE_CODE);
      mdl_hi = '0;
      mdl_lo = '0;
      mdl_dz = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   initial begin
      logic         sg;
      logic [W-1:0] a, b;
      #12;
      check("init_busy", Busy, 0);
      check("init_end", EndDivFlag, 0);
      check("init_dz", DivZero, 0);
      check("init_hi", Hi, 0);
      check("init_lo", Lo, 0);
      check("init_state", dbg_state, IDLE_CODE);
      @(negedge Clk);
      Reset = 1'b0;

      run_op(1'b0, 32'd100, 32'd7, 1'b0);
      check("lo_100_7", Lo, 14);
      check("hi_100_7", Hi, 2);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("lo_s_m7_2", Lo, 64'hFFFF_FFFD);
      check("hi_s_m7_2", Hi, 64'hFFFF_FFFF);
      run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("lo_u_m7_2", Lo, 64'h7FFF_FFFC);
      check("hi_u_m7_2", Hi, 1);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("lo_ovf", Lo, 64'h8000_0000);
      check("hi_ovf", Hi, 0);

      run_op(1'b0, 32'd100, 32'd7, 1'b0);
      run_op(1'b0, 32'd55, 32'd0, 1'b0);
      check("lo_dz_keep", Lo, 14);
      check("hi_dz_keep", Hi, 2);
      run_op(1'b1, 32'hFFFF_FF00, 32'd9, 1'b0);

      run_op(1'b0, 32'd1000, 32'd13, 1'b1);

      for (int i = 0; i < 24; i++) begin
         sg = 1'($urandom);
         case ($urandom_range(0, 4))
            0:       a = 32'h8000_0000;
            1:       a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = 32'hFFFF_FFFF;
            2, 3:    b = $urandom_range(1, 300);
            default: b = $urandom;
         endcase
         run_op(sg, a, b, 1'($urandom_range(0, 3) == 0));
      end

      run_op(1'b0, 32'd100, 32'd7, 1'b0);
      reset_mid_op(32'd5000, 32'd3);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("lo_after_rst", Lo, 64'hFFFF_FFFF);
      check("hi_after_rst", Hi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
